// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU definitions for the fetch unit: word width, default reset PC
// and the fetch FSM state encoding.
package pc_fetch_unit_pkg;

    localparam int          WORD_W           = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Decode-to-fetch bundle.
//   master (decode side): drives halt_req, redirect controls and operands,
//                         reads pc, pc_plus4, rom_addr.
//   slave  (fetch unit) : the reverse.
interface pc_fetch_unit_if;
    import pc_fetch_unit_pkg::*;

    logic              halt_req;
    logic              jr;
    logic              jump;
    logic              branch_taken;
    logic              branch_cond;
    logic [WORD_W-1:0] jr_target;
    logic [25:0]       instr_index;
    logic [WORD_W-1:0] ext18;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;
    logic [9:0]        rom_addr;

    modport master (
        output halt_req, jr, jump, branch_taken, branch_cond,
               jr_target, instr_index, ext18,
        input  pc, pc_plus4, rom_addr
    );

    modport slave (
        input  halt_req, jr, jump, branch_taken, branch_cond,
               jr_target, instr_index, ext18,
        output pc, pc_plus4, rom_addr
    );
endinterface

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// next_pc_sel: combinational next-PC priority mux.
//   Inputs : pc_plus4, jr/jump/branch_taken controls, jr_target,
//            instr_index, ext18.
//   Output : next_pc (always word aligned).
// Priority is jr > jump > branch_taken > sequential.
module next_pc_sel
    import pc_fetch_unit_pkg::*;
(
    input  logic [WORD_W-1:0] pc_plus4,
    input  logic              jr,
    input  logic              jump,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] jr_target,
    input  logic [25:0]       instr_index,
    input  logic [WORD_W-1:0] ext18,
    output logic [WORD_W-1:0] next_pc
);

    logic [WORD_W-1:0] branch_sum;

    // Wraps modulo 2^32 by truncation.
    assign branch_sum = pc_plus4 + ext18;

    always_comb begin
        next_pc = pc_plus4;
        if (jr)
            next_pc = {jr_target[31:2], 2'b00};
        else if (jump)
            next_pc = {pc_plus4[31:28], instr_index, 2'b00};
        else if (branch_taken)
            next_pc = {branch_sum[31:2], 2'b00};
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, halt/single-step FSM, go edge detector and
// saturating statistics counters.
//   clk, rst_n : system clock, async active-low reset
//   go         : operator button (level); a rising edge steps out of HALT
//   fetch      : decode bundle (slave side), returns pc/pc_plus4/rom_addr
//   halted     : high while in HALT
//   cycle_cnt / jump_cnt / branch_cnt : saturating statistics
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | normal fetch; pc advances unless halt_req
// ST_HALT | pc frozen, redirects ignored, waiting for go rising edge
// ST_STEP | execute the halting instruction once, then back to RUN
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    pc_fetch_unit_if.slave   fetch,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] jump_cnt,
    output logic [CNT_W-1:0] branch_cnt
);

    fetch_state_t      state, state_nxt;
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] next_pc;
    logic              go_q;
    logic              go_rise;
    logic              pc_load;

    assign fetch.pc       = pc_q;
    assign fetch.pc_plus4 = pc_q + 32'd4;
    assign fetch.rom_addr = pc_q[11:2];

    // go_q resets high so a button held through reset is not a fresh edge.
    assign go_rise = go & ~go_q;

    next_pc_sel u_next_pc_sel (
        .pc_plus4     (fetch.pc_plus4),
        .jr           (fetch.jr),
        .jump         (fetch.jump),
        .branch_taken (fetch.branch_taken),
        .jr_target    (fetch.jr_target),
        .instr_index  (fetch.instr_index),
        .ext18        (fetch.ext18),
        .next_pc      (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            go_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            go_q  <= go;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (fetch.halt_req) state_nxt = ST_HALT;
            ST_HALT: if (go_rise)        state_nxt = ST_STEP;
            ST_STEP: state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        pc_load = 1'b0;
        case (state)
            ST_RUN:  pc_load = ~fetch.halt_req;
            ST_STEP: pc_load = 1'b1;
            default: pc_load = 1'b0;
        endcase
    end

    // Decoded from the state register only, so no input-to-output path.
    assign halted = (state == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            cycle_cnt  <= '0;
            jump_cnt   <= '0;
            branch_cnt <= '0;
        end else if (pc_load) begin
            pc_q <= next_pc;
            if (cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if ((fetch.jr || fetch.jump) && jump_cnt != '1)
                jump_cnt <= jump_cnt + CNT_W'(1);
            if (fetch.branch_cond && branch_cnt != '1)
                branch_cnt <= branch_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit. A second, narrow-counter
// instance runs alongside to reach counter saturation quickly.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic go;
    logic halted, sat_halted;
    logic [31:0] cycle_cnt, jump_cnt, branch_cnt;
    logic [2:0]  sat_cycle_cnt, sat_jump_cnt, sat_branch_cnt;

    int total = 0;
    int bad   = 0;

    pc_fetch_unit_if bus ();
    pc_fetch_unit_if sat_bus ();

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (go),
        .fetch      (bus.slave),
        .halted     (halted),
        .cycle_cnt  (cycle_cnt),
        .jump_cnt   (jump_cnt),
        .branch_cnt (branch_cnt)
    );

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(3)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (1'b0),
        .fetch      (sat_bus.slave),
        .halted     (sat_halted),
        .cycle_cnt  (sat_cycle_cnt),
        .jump_cnt   (sat_jump_cnt),
        .branch_cnt (sat_branch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.halt_req     = 1'b0;
        bus.jr           = 1'b0;
        bus.jump         = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_cond  = 1'b0;
        bus.jr_target    = 32'h0;
        bus.instr_index  = 26'h0;
        bus.ext18        = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        go    = 1'b0;
        idle();
        // Narrow instance: jump + branch_cond every cycle, pc stays at 0.
        sat_bus.halt_req     = 1'b0;
        sat_bus.jr           = 1'b0;
        sat_bus.jump         = 1'b1;
        sat_bus.branch_taken = 1'b0;
        sat_bus.branch_cond  = 1'b1;
        sat_bus.jr_target    = 32'h0;
        sat_bus.instr_index  = 26'h0;
        sat_bus.ext18        = 32'h0;

        #23;
        chk("rst_pc",       bus.pc, 32'h0);
        chk("rst_pc_plus4", bus.pc_plus4, 32'h4);
        chk("rst_halted",   {31'b0, halted}, 32'h0);
        chk("rst_cycle",    cycle_cnt, 32'h0);
        #4 rst_n = 1'b1;

        // Four idle cycles: 4, 8, 12, 16.
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq_pc", bus.pc, 32'(i * 4));
        end
        chk("seq_cycle",   cycle_cnt, 32'd4);
        chk("seq_rom",     {22'b0, bus.rom_addr}, 32'd4);
        chk("sat_cnt_4",   {29'b0, sat_cycle_cnt}, 32'd4);

        // Jump to 0x40.
        bus.jump = 1'b1; bus.instr_index = 26'h10;
        tick();
        chk("jump_40", bus.pc, 32'h40);
        idle();

        // Backward taken branch: 0x44 - 8 = 0x3C.
        bus.branch_taken = 1'b1; bus.branch_cond = 1'b1; bus.ext18 = 32'hFFFF_FFF8;
        tick();
        chk("br_taken_pc", bus.pc, 32'h3C);
        chk("br_taken_cnt", branch_cnt, 32'd1);
        idle();

        // Not-taken branch still counts.
        bus.branch_cond = 1'b1; bus.ext18 = 32'hFFFF_FFF8;
        tick();
        chk("br_not_pc",  bus.pc, 32'h40);
        chk("br_not_cnt", branch_cnt, 32'd2);
        idle();

        bus.jr = 1'b1; bus.jr_target = 32'h3000_0010;
        tick();
        chk("jr_pc", bus.pc, 32'h3000_0010);
        idle();

        // Jump keeps pc_plus4[31:28].
        bus.jump = 1'b1; bus.instr_index = 26'h100;
        tick();
        chk("jump_region", bus.pc, 32'h3000_0400);
        idle();

        bus.jr = 1'b1; bus.jr_target = 32'h3000_0010;
        tick();
        idle();

        // All redirects together: jr wins, target low bits cleared.
        bus.jr = 1'b1; bus.jr_target = 32'h0000_0207;
        bus.jump = 1'b1; bus.instr_index = 26'h100;
        bus.branch_taken = 1'b1; bus.ext18 = 32'h0000_0100;
        tick();
        chk("prio_pc",  bus.pc, 32'h0000_0204);
        chk("prio_jcnt", jump_cnt, 32'd5);
        idle();

        // Wrap at top of address space.
        bus.jr = 1'b1; bus.jr_target = 32'hFFFF_FFFC;
        tick();
        chk("top_pc", bus.pc, 32'hFFFF_FFFC);
        chk("top_plus4", bus.pc_plus4, 32'h0);
        idle();
        tick();
        chk("wrap_pc", bus.pc, 32'h0);

        bus.jr = 1'b1; bus.jr_target = 32'h20;
        tick();
        chk("to_20", bus.pc, 32'h20);
        chk("cycle_14", cycle_cnt, 32'd14);
        idle();

        // Halt at 0x20; redirect held high must be ignored.
        bus.halt_req = 1'b1; bus.jump = 1'b1; bus.instr_index = 26'h3FF;
        tick();
        chk("halt_flag", {31'b0, halted}, 32'h1);
        chk("halt_pc",   bus.pc, 32'h20);
        for (int i = 0; i < 10; i++) tick();
        chk("halt_hold_pc", bus.pc, 32'h20);
        chk("halt_hold_cyc", cycle_cnt, 32'd14);
        chk("halt_hold_jcnt", jump_cnt, 32'd7);
        chk("halt_hold_flag", {31'b0, halted}, 32'h1);

        // go held high for 5 cycles: exactly one step.
        bus.jump = 1'b0; bus.instr_index = 26'h0;
        go = 1'b1;
        tick();
        chk("step_enter_pc", bus.pc, 32'h20);
        chk("step_enter_flag", {31'b0, halted}, 32'h0);
        tick();
        chk("step_pc",  bus.pc, 32'h24);
        chk("step_run", {31'b0, halted}, 32'h0);
        chk("step_cyc", cycle_cnt, 32'd15);
        for (int i = 0; i < 3; i++) tick();
        chk("no_retrig_pc", bus.pc, 32'h24);
        chk("no_retrig_flag", {31'b0, halted}, 32'h1);
        chk("no_retrig_cyc", cycle_cnt, 32'd15);

        chk("sat_cycle",  {29'b0, sat_cycle_cnt}, 32'd7);
        chk("sat_jump",   {29'b0, sat_jump_cnt}, 32'd7);
        chk("sat_branch", {29'b0, sat_branch_cnt}, 32'd7);
        tick();
        chk("sat_cycle_hold", {29'b0, sat_cycle_cnt}, 32'd7);

        // Asynchronous reset mid-HALT, away from any rising edge.
        #3 rst_n = 1'b0;
        #1;
        chk("arst_pc",     bus.pc, 32'h0);
        chk("arst_halted", {31'b0, halted}, 32'h0);
        chk("arst_cycle",  cycle_cnt, 32'h0);
        chk("arst_jump",   jump_cnt, 32'h0);
        #2 rst_n = 1'b1;

        // go still high across reset, halt_req high: halts at 0, no step.
        tick();
        chk("post_rst_halt", {31'b0, halted}, 32'h1);
        tick();
        tick();
        chk("held_go_pc",   bus.pc, 32'h0);
        chk("held_go_flag", {31'b0, halted}, 32'h1);

        // Fresh edge steps once.
        go = 1'b0;
        tick();
        go = 1'b1;
        tick();
        tick();
        chk("fresh_step_pc", bus.pc, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter CNT_W, default 32, width of each statistics counter.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 halt_req  input  1  high when the decoded instruction is a halting syscall (complement of the PC-enable term).
REQ-006 go  input  1  level operator button; a rising edge resumes from halt.
REQ-007 jr  input  1  jump-register instruction.
REQ-008 jump  input  1  J/JAL instruction.
REQ-009 branch_taken  input  1  conditional branch with condition true.
REQ-010 branch_cond  input  1  current instruction is a conditional branch, taken or not.
REQ-011 jr_target  input  32  register operand R1 value.
REQ-012 instr_index  input  26  instruction bits [25:0].
REQ-013 ext18  input  32  sign-extended immediate shifted left by 2.
REQ-014 pc  output  32  current instruction address.
REQ-015 pc_plus4  output  32  pc + 4, modulo 2^32; feeds the JAL link-data path.
REQ-016 rom_addr  output  10  pc[11:2], instruction ROM word address.
REQ-017 halted  output  1  high while in HALT.
REQ-018 cycle_cnt, jump_cnt, branch_cnt  output  CNT_W each  statistics counters.

Function
REQ-019 Next PC is selected in fixed priority: jr -> {jr_target[31:2],2'b00}; else jump -> {pc_plus4[31:28],instr_index,2'b00}; else branch_taken -> pc_plus4+ext18 with bits [1:0] forced to 0; else pc_plus4.
REQ-020 All address arithmetic is 32-bit and wraps modulo 2^32; pc 32'hFFFFFFFC with no redirect advances to 32'h00000000.
REQ-021 FSM states are RUN, HALT and STEP.
REQ-022 RUN: pc loads next PC each cycle with halt_req low; with halt_req high, pc holds and state goes to HALT on that edge.
REQ-023 HALT: pc holds; a go rising edge (go high this cycle, low the previous sampled cycle) moves the state to STEP.
REQ-024 STEP: pc loads next PC unconditionally, executing the halting instruction once, and the state returns to RUN.
REQ-025 go held high does not re-trigger STEP; a new low-to-high transition is required.
REQ-026 halted = (state == HALT), registered with no combinational path from inputs.
REQ-027 cycle_cnt increments on every edge where pc updates.
REQ-028 jump_cnt increments on updating edges with jr or jump high.
REQ-029 branch_cnt increments on updating edges with branch_cond high, whether or not the branch is taken.
REQ-030 All counters saturate at all-ones and do not wrap.
REQ-031 Simultaneous jr, jump and branch_taken: only the highest-priority redirect is applied, and jump_cnt increments once.
REQ-032 Redirect inputs are ignored while in HALT.
REQ-033 Latency: a redirect asserted in cycle N is visible on pc in cycle N+1.

Reset
REQ-034 While rst_n is low, regardless of clk: pc = RESET_PC, state = RUN, all counters = 0, go-edge register = 1 so that a held button does not step immediately after reset.
REQ-035 Reset asserted mid-HALT or mid-STEP aborts the operation and returns the FSM to RUN.
REQ-036 Resulting output values in reset: pc_plus4 = RESET_PC+4, halted = 0.

Structure
REQ-037 The shared cpu package holds the FSM state enum (RUN, HALT, STEP), the RESET_PC default and the 32-bit word width constant.
REQ-038 The next-PC priority mux is a separate combinational sub-module, next_pc_sel.
REQ-039 The FSM, PC register, edge detector and counters are in pc_fetch_unit.

Verification
REQ-040 Reset, then 4 idle cycles -> pc 0,4,8,12,16; cycle_cnt=4; rom_addr=4 at pc=16.
REQ-041 pc=0x00000040, ext18=0xFFFFFFF8, branch_taken=1, branch_cond=1 -> next pc=0x0000003C; branch_cnt=1.
REQ-042 pc=0x30000010, jump=1, instr_index=0x0000100, and jr=1, jr_target=0x00000207 in the same cycle -> pc=0x00000204; jump_cnt=1.
REQ-043 halt_req=1 at pc=0x20 -> halted=1 next cycle, pc holds at 0x20 for 10 cycles with go low, and cycle_cnt frozen.
REQ-044 Then go held high for 5 cycles -> exactly one step to pc=0x24, with the FSM back in RUN.
REQ-045 Counters preset near saturation by forcing -> after ≥2 updating cycles they hold all-ones.
REQ-046 rst_n pulsed low mid-HALT, asynchronous to clk -> pc=RESET_PC and halted=0 immediately.
